// File: rtl/serial_adder_ctrl_if.sv
// Handshake, operand/result and full-adder links of the bit-serial adder sequencer.
// master = requester plus adder cell side, slave = the sequencer.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_cout;

    modport master (
        output start, op_a, op_b, carry_in, fa_sum, fa_cout,
        input  busy, done, result, carry_out, fa_a, fa_b, fa_cin
    );

    modport slave (
        input  start, op_a, op_b, carry_in, fa_sum, fa_cout,
        output busy, done, result, carry_out, fa_a, fa_b, fa_cin
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial addition sequencer: feeds a registered full adder one bit pair per
// DRIVE/SAMPLE step, LSB first, and publishes {carry_out,result} with a done pulse.
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    serial_adder_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_r,     state_s;
    logic [WIDTH-1:0] a_r,         a_s;
    logic [WIDTH-1:0] b_r,         b_s;
    logic [WIDTH-1:0] sum_r,       sum_s;
    logic [WIDTH-1:0] result_r,    result_s;
    logic [CNT_W-1:0] idx_r,       idx_s;
    logic             carry_r,     carry_s;
    logic             carry_out_r, carry_out_s;
    logic             busy_r,      busy_s;
    logic             done_r,      done_s;
    logic             fa_a_r,      fa_a_s;
    logic             fa_b_r,      fa_b_s;
    logic             fa_cin_r,    fa_cin_s;

    logic [CNT_W-1:0] idx_inc_s;
    logic             last_s;
    logic [WIDTH-1:0] cur_mask_s;
    logic [WIDTH-1:0] nxt_mask_s;
    logic [WIDTH-1:0] sum_upd_s;

    // Next-state and next-register values; fa_* are registered on entry to DRIVE
    // so the adder captures them at the end of DRIVE and answers during SAMPLE.
    always_comb begin
        state_s     = state_r;
        a_s         = a_r;
        b_s         = b_r;
        sum_s       = sum_r;
        result_s    = result_r;
        idx_s       = idx_r;
        carry_s     = carry_r;
        carry_out_s = carry_out_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        fa_a_s      = fa_a_r;
        fa_b_s      = fa_b_r;
        fa_cin_s    = fa_cin_r;

        idx_inc_s  = idx_r + CNT_W'(1);
        last_s     = (idx_r == CNT_W'(WIDTH - 1));
        cur_mask_s = WIDTH'(1'b1) << idx_r;
        nxt_mask_s = WIDTH'(1'b1) << idx_inc_s;
        if (bus.fa_sum) begin
            sum_upd_s = sum_r | cur_mask_s;
        end else begin
            sum_upd_s = sum_r & ~cur_mask_s;
        end

        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s  = DRIVE;
                    a_s      = bus.op_a;
                    b_s      = bus.op_b;
                    carry_s  = bus.carry_in;
                    idx_s    = '0;
                    busy_s   = 1'b1;
                    fa_a_s   = bus.op_a[0];
                    fa_b_s   = bus.op_b[0];
                    fa_cin_s = bus.carry_in;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
                state_s = SAMPLE;
            end
            SAMPLE: begin
                sum_s   = sum_upd_s;
                carry_s = bus.fa_cout;
                if (last_s) begin
                    state_s     = DONE;
                    busy_s      = 1'b0;
                    done_s      = 1'b1;
                    result_s    = sum_upd_s;
                    carry_out_s = bus.fa_cout;
                end else begin
                    state_s  = DRIVE;
                    idx_s    = idx_inc_s;
                    fa_a_s   = |(a_r & nxt_mask_s);
                    fa_b_s   = |(b_r & nxt_mask_s);
                    fa_cin_s = bus.fa_cout;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            result_r    <= '0;
            idx_r       <= '0;
            carry_r     <= 1'b0;
            carry_out_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fa_a_r      <= 1'b0;
            fa_b_r      <= 1'b0;
            fa_cin_r    <= 1'b0;
        end else begin
            a_r         <= a_s;
            b_r         <= b_s;
            sum_r       <= sum_s;
            result_r    <= result_s;
            idx_r       <= idx_s;
            carry_r     <= carry_s;
            carry_out_r <= carry_out_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            fa_a_r      <= fa_a_s;
            fa_b_r      <= fa_b_s;
            fa_cin_r    <= fa_cin_s;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.carry_out = carry_out_r;
    assign bus.fa_a      = fa_a_r;
    assign bus.fa_b      = fa_b_r;
    assign bus.fa_cin    = fa_cin_r;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8) driving a registered full adder model.
module tb_serial_adder_ctrl;
    localparam int WIDTH   = 8;
    localparam int LATENCY = 2 * WIDTH + 1;

    logic clock;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;

    logic [8:0] exp_q[$];
    int         cs_q[$];
    logic [8:0] last_exp;
    logic [8:0] mon_e;
    int         mon_c;

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Registered full adder cell: sum/cout one cycle after its inputs
    always @(posedge clock) begin
        bus.fa_sum  <= bus.fa_a ^ bus.fa_b ^ bus.fa_cin;
        bus.fa_cout <= (bus.fa_a & bus.fa_b) | (bus.fa_cin & (bus.fa_a ^ bus.fa_b));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding start
    always @(negedge clock) begin
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                n_checks = n_checks + 1;
                n_fail   = n_fail + 1;
                $display("FAIL unexpected_done: done=1 with no outstanding start (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = cs_q.pop_front();
                check("sum", 32'({bus.carry_out, bus.result}), 32'(mon_e));
                check("latency", 32'(cyc - mon_c), 32'(LATENCY));
            end
        end
    end

    // mode 0: plain, 1: busy profile, 2: stray starts mid-op and in DONE, 3: reset mid-op
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci, input int mode);
        int         cs;
        logic [8:0] e;
        logic [8:0] prev;
        e    = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        prev = last_exp;
        bus.start    = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.carry_in = ci;
        cs = cyc;
        if (mode != 3) begin
            exp_q.push_back(e);
            cs_q.push_back(cs);
            last_exp = e;
        end
        if (mode == 1) check("busy_accept_cycle", 32'(bus.busy), 32'(0));
        for (int k = 1; k <= LATENCY + 1; k++) begin
            @(negedge clock);
            if (k == 1) begin
                bus.start    = 1'b0;
                bus.op_a     = 8'($urandom);
                bus.op_b     = 8'($urandom);
                bus.carry_in = 1'($urandom);
            end
            if (mode == 1) check("busy_profile", 32'(bus.busy), 32'(k <= 2 * WIDTH));
            if (k == 8) check("result_held", 32'({bus.carry_out, bus.result}), 32'(prev));
            if (mode == 2 && k == 5) begin
                bus.start = 1'b1;
                bus.op_a  = 8'hAA;
            end
            if (mode == 2 && k == 6) bus.start = 1'b0;
            if (mode == 2 && k == LATENCY) begin
                bus.start = 1'b1;
                bus.op_a  = 8'h55;
            end
            if (mode == 2 && k == LATENCY + 1) bus.start = 1'b0;
            if (mode == 3 && k == 8) begin
                reset = 1'b1;
                #1;
                check("abort_busy", 32'(bus.busy), 32'(0));
                check("abort_done", 32'(bus.done), 32'(0));
                check("abort_result", 32'({bus.carry_out, bus.result}), 32'(0));
                check("abort_fa", 32'({bus.fa_a, bus.fa_b, bus.fa_cin}), 32'(0));
                last_exp = 9'd0;
            end
            if (mode == 3 && k == 9) reset = 1'b0;
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        cyc          = 0;
        last_exp     = 9'd0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.op_a     = 8'h00;
        bus.op_b     = 8'h00;
        bus.carry_in = 1'b0;

        @(negedge clock);
        check("reset_busy", 32'(bus.busy), 32'(0));
        check("reset_done", 32'(bus.done), 32'(0));
        check("reset_result", 32'({bus.carry_out, bus.result}), 32'(0));
        check("reset_fa", 32'({bus.fa_a, bus.fa_b, bus.fa_cin}), 32'(0));
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        do_op(8'h05, 8'h03, 1'b0, 1);
        do_op(8'hFF, 8'h01, 1'b0, 0);
        do_op(8'hFF, 8'hFF, 1'b1, 0);
        do_op(8'h7F, 8'h01, 1'b0, 3);
        do_op(8'h7F, 8'h01, 1'b0, 0);
        do_op(8'h12, 8'h34, 1'b1, 2);
        do_op(8'h0F, 8'hF0, 1'b0, 0);
        do_op(8'h00, 8'h00, 1'b0, 0);
        for (int i = 0; i < 200; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 0);
        end

        repeat (4) @(negedge clock);
        check("outstanding_starts", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
